// File: rtl/scrapcpu_pkg.sv
// Shared definitions for the scrapcpu instruction-fetch path: SPI command
// opcode, fetch FSM states and the READ command word builder.
package scrapcpu_pkg;

   localparam logic [7:0]  CMD_READ          = 8'h03;
   localparam logic [23:0] DEFAULT_BASE_ADDR = 24'h000000;

   localparam int BIT_CNT_W = 6;
   // A cold access is one continuous 40-bit frame: 32 command/address bits
   // followed by 8 data bits. A sequential access is just the 8 data bits.
   localparam logic [BIT_CNT_W-1:0] COLD_BITS = 6'd40;
   localparam logic [BIT_CNT_W-1:0] SEQ_BITS  = 6'd8;
   localparam logic [BIT_CNT_W-1:0] CMD_LAST  = 6'd9;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_DATA,
      ST_HOLD,
      ST_DESEL
   } fetch_state_t;

   function automatic logic [31:0] read_cmd_word(input logic [23:0] base,
                                                 input logic [23:0] pc);
      return {CMD_READ, base + pc};
   endfunction

endpackage

// File: rtl/scrapcpu_spi_shifter.sv
// SPI mode-0 bit engine: CLK_DIV-cycle half periods, MSB-first shift-out of a
// 32-bit word, MSB-first shift-in of the last 8 bits, one bit_end per bit.
module scrapcpu_spi_shifter
   import scrapcpu_pkg::*;
#(
   parameter int CLK_DIV = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [BIT_CNT_W-1:0] len,
   input  logic [31:0]          tx_word,
   input  logic                 miso,
   output logic                 sclk,
   output logic                 mosi,
   output logic                 bit_end,
   output logic [BIT_CNT_W-1:0] remaining,
   output logic [7:0]           rx_byte
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic             active;
   logic [DIV_W-1:0] div_cnt;
   logic [31:0]      tx_sh;
   logic             half_end;

   assign half_end = active && (div_cnt == DIV_LAST);
   assign bit_end  = half_end && sclk;
   // Zeros shift in behind the command, so mosi rests low once it is sent.
   assign mosi     = tx_sh[31];

   always_ff @(posedge clk) begin
      if (rst) begin
         active    <= 1'b0;
         sclk      <= 1'b0;
         div_cnt   <= '0;
         remaining <= '0;
         tx_sh     <= '0;
         rx_byte   <= '0;
      end else if (start) begin
         active    <= 1'b1;
         sclk      <= 1'b0;
         div_cnt   <= '0;
         remaining <= len;
         tx_sh     <= tx_word;
      end else if (active) begin
         if (half_end) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
            // Capture miso on the edge where sclk rises.
            if (!sclk) begin
               rx_byte <= {rx_byte[6:0], miso};
            end else begin
               tx_sh     <= {tx_sh[30:0], 1'b0};
               remaining <= remaining - BIT_CNT_W'(1);
               if (remaining == BIT_CNT_W'(1)) begin
                  active <= 1'b0;
               end
            end
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end
      end
   end

endmodule

// File: rtl/scrapcpu_rom_fetch.sv
// Instruction fetch from W25Q128JV over SPI READ; keeps CS low across sequential
// fetches (16*CLK_DIV cycles each), cold/jump fetches cost a full 80*CLK_DIV frame.
module scrapcpu_rom_fetch
   import scrapcpu_pkg::*;
#(
   parameter int          PC_W        = 10,
   parameter logic [23:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
   parameter int          CLK_DIV     = 2,
   parameter int          CS_HIGH_CYC = 4
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_i,
   input  logic            fetch_req,
   input  logic [PC_W-1:0] fetch_addr,
   output logic            busy,
   output logic            instr_valid,
   output logic [7:0]      instr,
   output logic            rom_cs_n,
   output logic            rom_sclk,
   output logic            rom_mosi,
   input  logic            rom_miso,
   output logic            rom_wp_n,
   output logic            rom_hold_n
);

   localparam int DSL_W = (CS_HIGH_CYC > 1) ? $clog2(CS_HIGH_CYC) : 1;
   localparam logic [DSL_W-1:0] DSL_LAST = DSL_W'(CS_HIGH_CYC - 1);

   fetch_state_t         state, state_nxt;
   logic [PC_W-1:0]      last_addr;
   logic [PC_W-1:0]      addr_inc;
   logic [PC_W-1:0]      cmd_pc;
   logic [DSL_W-1:0]     desel_cnt;
   logic                 accept;
   logic                 seq_hit;
   logic                 finish;
   logic                 sh_start;
   logic [BIT_CNT_W-1:0] sh_len;
   logic [31:0]          sh_word;
   logic                 sh_bit_end;
   logic [BIT_CNT_W-1:0] sh_remaining;
   logic [7:0]           sh_rx;

   assign rom_wp_n   = 1'b1;
   assign rom_hold_n = 1'b1;

   // busy stays up through the instr_valid cycle, so a request is only taken
   // in IDLE or HOLD once the previous response has been delivered.
   assign busy     = (state == ST_CMD) || (state == ST_DATA) || (state == ST_DESEL) || instr_valid;
   assign accept   = fetch_req && !busy;
   assign addr_inc = last_addr + PC_W'(1);
   // A wrap from all-ones back to zero must re-issue the command.
   assign seq_hit  = (last_addr != '1) && (fetch_addr == addr_inc);

   always_comb begin
      state_nxt = state;
      sh_start  = 1'b0;
      sh_len    = COLD_BITS;
      cmd_pc    = last_addr;
      finish    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               state_nxt = ST_CMD;
               sh_start  = 1'b1;
               cmd_pc    = fetch_addr;
            end
         end
         ST_CMD: begin
            if (sh_bit_end && (sh_remaining == CMD_LAST)) begin
               state_nxt = ST_DATA;
            end
         end
         ST_DATA: begin
            if (sh_bit_end && (sh_remaining == BIT_CNT_W'(1))) begin
               state_nxt = ST_HOLD;
               finish    = 1'b1;
            end
         end
         ST_HOLD: begin
            if (accept) begin
               if (seq_hit) begin
                  state_nxt = ST_DATA;
                  sh_start  = 1'b1;
                  sh_len    = SEQ_BITS;
               end else begin
                  state_nxt = ST_DESEL;
               end
            end
         end
         ST_DESEL: begin
            if (desel_cnt == DSL_LAST) begin
               state_nxt = ST_CMD;
               sh_start  = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      sh_word = (sh_len == SEQ_BITS) ? 32'h0 : read_cmd_word(BASE_ADDR, 24'(cmd_pc));
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state       <= ST_IDLE;
         last_addr   <= '0;
         desel_cnt   <= '0;
         instr_valid <= 1'b0;
         instr       <= 8'h00;
         rom_cs_n    <= 1'b1;
      end else begin
         state       <= state_nxt;
         instr_valid <= finish;
         rom_cs_n    <= (state_nxt == ST_IDLE) || (state_nxt == ST_DESEL);
         if (finish) begin
            instr <= sh_rx;
         end
         if (accept) begin
            last_addr <= fetch_addr;
         end
         desel_cnt <= (state == ST_DESEL) ? desel_cnt + DSL_W'(1) : '0;
      end
   end

   scrapcpu_spi_shifter #(
      .CLK_DIV (CLK_DIV)
   ) u_shifter (
      .clk       (wb_clk_i),
      .rst       (wb_rst_i),
      .start     (sh_start),
      .len       (sh_len),
      .tx_word   (sh_word),
      .miso      (rom_miso),
      .sclk      (rom_sclk),
      .mosi      (rom_mosi),
      .bit_end   (sh_bit_end),
      .remaining (sh_remaining),
      .rx_byte   (sh_rx)
   );

endmodule

// File: doc/scrapcpu_rom_fetch.md
# scrapcpu_rom_fetch

Instruction-fetch front end for scrapcpu. It turns the CPU's per-instruction address requests into SPI READ (0x03) transactions on the external W25Q128JV program flash, and returns one 8-bit instruction byte per request. The block keeps CS asserted between sequential fetches, so straight-line code costs only 8 SCLK periods per instruction. Non-sequential fetches (jumps) deselect the flash and issue a fresh command.

## Interface
Parameters:
- PC_W, 10, CPU program-counter width; flash address = BASE_ADDR + zero-extended fetch_addr
- BASE_ADDR, 24'h000000, flash byte offset of program image
- CLK_DIV, 2, wb_clk_i cycles per SCLK half-period (≥1)
- CS_HIGH_CYC, 4, minimum cycles rom_cs_n stays high between transactions (≥1)

Ports:
- wb_clk_i  in  1  sole clock
- wb_rst_i  in  1  synchronous, active-high reset
- fetch_req  in  1  request strobe; accepted only when busy=0
- fetch_addr  in  PC_W  instruction address, sampled on acceptance
- busy  out  1  high from acceptance through the instr_valid cycle; reset 0
- instr_valid  out  1  one-cycle pulse, instr valid; reset 0
- instr  out  8  fetched byte, held until next instr_valid; reset 0
- rom_cs_n  out  1  flash chip select; reset 1
- rom_sclk  out  1  SPI clock, mode 0; reset 0
- rom_mosi  out  1  to flash DI; reset 0
- rom_miso  in  1  from flash DO
- rom_wp_n, rom_hold_n  out  1  tied 1

## Operation
- States: IDLE (cs_n=1), CMD (32 bits out: 0x03 then 24-bit address, MSB first), DATA (8 bits in, MSB first), HOLD (cs_n=0, sclk=0, awaiting next request), DESEL (cs_n=1 for CS_HIGH_CYC cycles).
- IDLE + accepted req → CMD. CMD after bit 32 → DATA. DATA after bit 8 → instr_valid pulse, latch instr, → HOLD.
- HOLD + req with fetch_addr == last_addr+1 (no PC wrap) → DATA directly (flash auto-increments).
- HOLD + any other addr → DESEL → CMD.
- PC wrap: last_addr = all-ones, fetch_addr = 0 → non-sequential path.
- Repeated address (fetch_addr == last_addr) → non-sequential path; no caching.
- fetch_req while busy=1: ignored, no effect.
- Reset mid-transaction: next edge cs_n=1, sclk=0, mosi=0, state IDLE, no instr_valid, sequential tracking cleared (first fetch after reset is always cold).

## Timing
- SPI mode 0: mosi updates while sclk low, at the start of each bit; sclk high for CLK_DIV cycles, low for CLK_DIV; rom_miso sampled on the cycle sclk rises.
- Request accepted in cycle T (IDLE or HOLD): busy=1 from T+1.
- Cold (from IDLE): cs_n falls T+1; instr_valid at T+1+80·CLK_DIV.
- Sequential (from HOLD): instr_valid at T+1+16·CLK_DIV.
- Jump (from HOLD): cs_n high T+1..T+CS_HIGH_CYC; instr_valid at T+1+CS_HIGH_CYC+80·CLK_DIV.
- busy drops the cycle after instr_valid; a req in that cycle is accepted.
- sclk ends low after every transaction; no partial SCLK pulses at any state change or reset.

## Structure
- Shared package scrapcpu_pkg: CMD_READ = 8'h03, fetch-state enum, default BASE_ADDR.
- One sub-module, scrapcpu_spi_shifter: CLK_DIV prescaler, sclk generation, 32-bit MSB-first shift-out / 8-bit shift-in, bit counter, done strobe. The top level holds the FSM, address latch and sequential compare.

## Test plan
- Cold fetch, CLK_DIV=2, BASE_ADDR=0, flash[5]=8'hA7, req addr 5 → MOSI stream 03 00 00 05; instr=8'hA7, instr_valid exactly 161 cycles after acceptance; cs_n stays 0 afterwards.
- Sequential run at addrs 5,6,7 (flash 8'hA7,8'h3C,8'hFF) → 2nd/3rd responses each 33 cycles after acceptance; no extra cs_n toggles.
- Jump from HOLD (addr 7 → 2) → cs_n high exactly 4 cycles, new command 03 00 00 02, latency 165 cycles.
- PC wrap, PC_W=10: addr 10'h3FF then 0 → cs_n deasserts, new command with address 000000, byte from flash[0].
- wb_rst_i asserted mid-CMD → next cycle cs_n=1, sclk=0, busy=0, no instr_valid; next fetch is cold and returns the correct byte.
- fetch_req pulsed while busy → ignored; only the original address returned, single instr_valid.
